key_jitter: RTL and testbench

//  Debounces one mechanical push-button (active-low, asynchronous to clk) and counts

---
 rtl/key_jitter_pkg.sv | 32 +++
 rtl/key_debounce.sv | 83 ++++++++
 rtl/key_jitter.sv | 63 ++++++
 tb/tb_key_jitter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/key_jitter_pkg.sv
// ----------------------------------------------------------------------------
// key_jitter_pkg
//   Shared constants for the push-button debouncer and LED press counter.
//   - LED_W                 : width of the LED press counter
//   - DEBOUNCE_CYCLES_DEF   : default debounce window in clk cycles
//   - CNT_W_DEF             : default debounce counter width
//   - KEY_ACTIVE_LOW_DEF    : default key polarity (1 = pressed when low)
//   - RELEASED / PRESSED    : key levels for the default polarity
//   - released_level()      : released key level for a given polarity
// ----------------------------------------------------------------------------
package key_jitter_pkg;

  localparam int unsigned LED_W               = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
  localparam int unsigned CNT_W_DEF           = 16;
  localparam bit          KEY_ACTIVE_LOW_DEF  = 1'b1;

  // Level the pin rests at when nobody touches the button.
  function automatic logic released_level(input bit active_low);
    logic lvl;
    if (active_low) begin
      lvl = 1'b1;
    end else begin
      lvl = 1'b0;
    end
    return lvl;
  endfunction

  localparam logic RELEASED = released_level(KEY_ACTIVE_LOW_DEF);
  localparam logic PRESSED  = ~released_level(KEY_ACTIVE_LOW_DEF);

endpackage : key_jitter_pkg

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
//   Two-flop synchronizer, debounce counter and accepted-level register for
//   one raw button input. Emits a one-cycle pulse when the accepted level
//   moves from released to pressed.
//   Ports:
//     clk     in   system clock, rising edge
//     rst     in   synchronous reset, active-high
//     key     in   raw button level, asynchronous, bouncy
//     press_o out  one-cycle pulse per accepted press (registered)
// ----------------------------------------------------------------------------
module key_debounce
  import key_jitter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter bit          KEY_ACTIVE_LOW  = KEY_ACTIVE_LOW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press_o
);

  localparam logic             REL_LVL  = released_level(KEY_ACTIVE_LOW);
  localparam logic             PRS_LVL  = ~released_level(KEY_ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1_d,  sync1_q;
  logic             sync2_d,  sync2_q;   // sync2_q is the synchronized key
  logic [CNT_W-1:0] cnt_d,    cnt_q;
  logic             stable_d, stable_q;
  logic             press_d,  press_q;

  // Next-state logic: synchronizer shift, debounce window, press edge.
  always_comb begin
    sync1_d  = key;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;

    if (sync2_q == stable_q) begin
      // Any return to the accepted level restarts the window.
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      // New level persisted for the whole window: accept it.
      stable_d = sync2_q;
      cnt_d    = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // Only released->pressed produces a pulse; releases are silent.
    if ((stable_q == REL_LVL) && (stable_d == PRS_LVL)) begin
      press_d = 1'b1;
    end else begin
      press_d = 1'b0;
    end
  end

  // State registers; reset puts everything at the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= REL_LVL;
      sync2_q  <= REL_LVL;
      cnt_q    <= CNT_ZERO;
      stable_q <= REL_LVL;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule : key_debounce

// File: rtl/key_jitter.sv
// ----------------------------------------------------------------------------
// key_jitter
//   Debounces one mechanical push-button and counts validated presses on a
//   4-bit LED bus (modulo 16). Latency from key edge to LED change is
//   2 (sync) + DEBOUNCE_CYCLES + 1 clk cycles.
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   synchronous reset, active-high
//     key  in   raw button level, asynchronous, bouncy
//     led  out  count of debounced presses, modulo 16 (registered)
// ----------------------------------------------------------------------------
module key_jitter
  import key_jitter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter bit          KEY_ACTIVE_LOW  = KEY_ACTIVE_LOW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key,
  output logic [LED_W-1:0] led
);

  localparam logic [LED_W-1:0] LED_ONE  = LED_W'(1);
  localparam logic [LED_W-1:0] LED_ZERO = LED_W'(0);

  logic             press_s;
  logic [LED_W-1:0] led_d, led_q;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .press_o (press_s)
  );

  // Press counter next state; natural 4-bit wrap from F to 0.
  always_comb begin
    led_d = led_q;
    if (press_s) begin
      led_d = led_q + LED_ONE;
    end else begin
      led_d = led_q;
    end
  end

  // LED count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= LED_ZERO;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule : key_jitter

// File: tb/tb_key_jitter.sv
// ----------------------------------------------------------------------------
// tb_key_jitter
//   Scoreboard bench for key_jitter with a shortened debounce window.
//   Every accepted press pushes {expected led value, expected cycle}; a
//   negedge monitor pops and compares whenever led changes.
// ----------------------------------------------------------------------------
module tb_key_jitter;

  localparam int DEB = 16;
  localparam int LAT = DEB + 3;   // key edge -> led change, in clk cycles

  typedef struct {
    logic [3:0] val;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'bx;
  logic [3:0] led;

  int         cyc      = 0;
  int         n_total  = 0;
  int         n_bad    = 0;
  bit         mon_en   = 1'b0;
  logic [3:0] led_prev = 4'h0;
  logic [3:0] exp_led  = 4'h0;
  exp_t       sb_q[$];

  key_jitter #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (8),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .key (key),
    .led (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called on the negedge where key is driven to the pressed level.
  task automatic expect_press();
    exp_t e;
    exp_led = exp_led + 4'h1;
    e.val   = exp_led;
    e.cyc   = cyc + LAT;
    sb_q.push_back(e);
  endtask

  task automatic hold_key(input logic lvl, input int n);
    key = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every led change must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      led_prev <= led;
    end else if (led !== led_prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_led_change", int'(led), int'(led_prev));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("led_value", int'(led), int'(e.val));
        chk("led_cycle", cyc, e.cyc);
      end
      led_prev <= led;
    end
  end

  initial begin
    // 1. Reset with X then toggling key; led must stay 0.
    rst = 1'b1;
    key = 1'bx;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk("reset_led", int'(led), 0);
    end
    key = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    hold_key(1'b1, 10 * DEB);
    chk("idle_after_reset", int'(led), 0);

    // 2. Bounce burst then hold: one increment from the final falling edge.
    hold_key(1'b0, 3);
    hold_key(1'b1, 5);
    hold_key(1'b0, 3);
    hold_key(1'b1, 8);
    expect_press();
    hold_key(1'b0, 4 * DEB);
    chk("bounce_press", int'(led), 1);

    // 3. Release burst then long release: no change.
    hold_key(1'b1, 3);
    hold_key(1'b0, 3);
    hold_key(1'b1, 6);
    hold_key(1'b0, 12);
    hold_key(1'b1, 4 * DEB);
    chk("release_no_change", int'(led), 1);

    // 4. Long hold gives a single increment, then 16 clean presses wrap.
    expect_press();
    hold_key(1'b0, 10 * DEB);
    hold_key(1'b1, 3 * DEB);
    chk("long_hold", int'(led), 2);
    for (int i = 0; i < 16; i++) begin
      expect_press();
      hold_key(1'b0, 2 * DEB);
      hold_key(1'b1, 2 * DEB);
    end
    chk("wrap_16", int'(led), 2);

    // 5. Glitch one cycle short of the window, then one just past it.
    hold_key(1'b0, DEB - 1);
    hold_key(1'b1, 3 * DEB);
    chk("short_glitch", int'(led), 2);
    expect_press();
    hold_key(1'b0, DEB + 2);
    hold_key(1'b1, 3 * DEB);
    chk("window_plus2", int'(led), 3);

    // 6. Reset mid-window; held key then counts as a fresh press.
    hold_key(1'b0, DEB / 2);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_window_reset", int'(led), 0);
    end
    exp_led = 4'h0;
    rst     = 1'b0;
    expect_press();
    hold_key(1'b0, 3 * DEB);
    hold_key(1'b1, 3 * DEB);

    chk("scoreboard_empty", sb_q.size(), 0);
    chk("final_led", int'(led), int'(exp_led));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_key_jitter
